// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and uart_send drive bundle for uart_tx_arbiter
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_byte;
    logic        tx_byte_en;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_done;

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_byte, tx_byte_en, busy, grant_id, tx_done
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_byte, tx_byte_en, busy, grant_id, tx_done
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_send among 4 byte requesters, frames paced by a local timer
// Define UART_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 highest).
module uart_tx_arbiter #(
    parameter logic [15:0] BPS_CNT  = 16'd434,
    parameter logic [3:0]  GAP_BITS = 4'd1,
    parameter logic [3:0]  EN_HOLD  = 4'd4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             tx_enable,
    uart_tx_arbiter_if.slave bus
);
    localparam logic [19:0] FRAME_LEN = 20'(BPS_CNT) * (20'd10 + 20'(GAP_BITS));

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [19:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_byte_en_q, tx_byte_en_d;
    logic        busy_q, busy_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic        tx_done_q, tx_done_d;
    logic [1:0]  winner;
    logic        found;
    logic        accept;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic [1:0]  rr_ptr_q, rr_ptr_d;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            tx_byte_q    <= '0;
            tx_byte_en_q <= 1'b0;
            busy_q       <= 1'b0;
            grant_id_q   <= '0;
            tx_done_q    <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            tx_byte_q    <= tx_byte_d;
            tx_byte_en_q <= tx_byte_en_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            tx_done_q    <= tx_done_d;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    // Winner search depends only on req_valid and registered state, never on req_ready.
    always_comb begin
        logic [1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < 4; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            idx = 2'(k);
`else
            idx = rr_ptr_q + 2'(k);
`endif
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign accept        = (state_q == IDLE) && tx_enable && found;
    assign bus.req_ready = accept ? (4'b0001 << winner) : 4'b0000;

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        tx_byte_d    = tx_byte_q;
        tx_byte_en_d = tx_byte_en_q;
        busy_d       = busy_q;
        grant_id_d   = grant_id_q;
        tx_done_d    = 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_byte_d    = bus.req_data[{winner, 3'b000} +: 8];
                    tx_byte_en_d = 1'b1;
                    grant_id_d   = winner;
                    frame_cnt_d  = '0;
                    busy_d       = 1'b1;
                    state_d      = SEND;
`ifndef UART_ARB_FIXED_PRIO_EN
                    rr_ptr_d     = winner + 2'd1;
`endif
                end
            end
            SEND: begin
                frame_cnt_d = frame_cnt_q + 20'd1;
                if (frame_cnt_q == 20'(EN_HOLD) - 20'd1)
                    tx_byte_en_d = 1'b0;
                // Returning to IDLE here leaves one idle cycle, so uart_send sees en low before the next rise.
                if (frame_cnt_q == FRAME_LEN - 20'd1) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    tx_done_d   = 1'b1;
                    frame_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_byte    = tx_byte_q;
    assign bus.tx_byte_en = tx_byte_en_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.tx_done    = tx_done_q;
endmodule
